// File: rtl/mem_req_ctrl.sv
// Single-outstanding request sequencer in front of the 32x32 RAM; writes take one r_w pulse, reads return after RD_LAT.
// Optional MEM_REQ_CTRL_STATS_EN adds saturating wr_count/rd_count outputs.
module mem_req_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [1:0] lat_cnt;
  logic       hs;
  logic       lat_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    lat_done  = (lat_cnt == LAST);
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          hs        = 1'b1;
          state_nxt = req_wr ? WRITE : READ;
        end
      end
      WRITE:   state_nxt = IDLE;
      READ:    if (lat_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so the RAM pins never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b0;
      mem_r_w   <= 1'b0;
      mem_addr  <= '0;
      mem_d_in  <= '0;
      lat_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      mem_r_w   <= (state_nxt == WRITE);
      if (hs) begin
        mem_addr <= req_addr;
        mem_d_in <= req_wdata;
        lat_cnt  <= '0;
      end else if (state == READ) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
      if (state == READ && lat_done) begin
        rsp_rdata <= mem_d_out;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef MEM_REQ_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (state == WRITE && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (state == RESP && rsp_ready && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl against a behavioural 32x32 RAM with a read-data scoreboard.
module tb_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy, mem_r_w;
  logic [4:0]  mem_addr;
  logic [31:0] mem_d_in, mem_d_out;
`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] wr_count, rd_count;
`endif

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_W(5), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_r_w(mem_r_w), .mem_addr(mem_addr),
    .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
`ifdef MEM_REQ_CTRL_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  // RAM model: two 16-bit halves, synchronous write, combinational read.
  logic [15:0] ram_hi [32];
  logic [15:0] ram_lo [32];
  int          wr_events = 0;
  always @(posedge clk) begin
    if (mem_r_w) begin
      ram_hi[mem_addr] <= mem_d_in[31:16];
      ram_lo[mem_addr] <= mem_d_in[15:0];
      wr_events++;
    end
  end
  assign mem_d_out = {ram_hi[mem_addr], ram_lo[mem_addr]};

  logic [31:0] shadow [32];
  logic [31:0] exp_q [$];
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request and return at the negedge after its handshake edge.
  task automatic send(input logic wr, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    if (wr) shadow[a] = d;
    else    exp_q.push_back(shadow[a]);
  endtask

  task automatic recv(input string tag);
    int n = 0;
    logic [31:0] e;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    chk(tag, rsp_rdata, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, rsp_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] held;
    int          seen;
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin ram_hi[i] = 16'h0; ram_lo[i] = 16'h0; end
    rst = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd3;
    req_wdata = 32'hAAAA_5555; rsp_ready = 1'b1;

    // Reset with a write request waiting at the inputs.
    repeat (3) @(negedge clk);
    chk("rst_r_w", mem_r_w, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 5'd0);
    chk("rst_d_in", mem_d_in, 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1'b1);
    chk("rel_no_write", wr_events, 0);

    // Write timing: r_w high for exactly the cycle after the handshake.
    send(1'b1, 5'd7, 32'hDEAD_BEEF);
    chk("wr_r_w", mem_r_w, 1'b1);
    chk("wr_addr", mem_addr, 5'd7);
    chk("wr_d_in", mem_d_in, 32'hDEAD_BEEF);
    chk("wr_req_ready", req_ready, 1'b0);
    chk("wr_busy", busy, 1'b1);
    @(negedge clk);
    chk("wr_r_w_off", mem_r_w, 1'b0);
    chk("wr_ready_back", req_ready, 1'b1);
    chk("wr_ram", {ram_hi[7], ram_lo[7]}, 32'hDEAD_BEEF);

    // Read latency: response valid after edge N+1.
    send(1'b0, 5'd7, 32'h0);
    chk("rd_busy", busy, 1'b1);
    chk("rd_r_w", mem_r_w, 1'b0);
    chk("rd_early", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rd_lat", rsp_valid, 1'b1);
    recv("rd7");

    // Both halves and both address extremes.
    send(1'b1, 5'd0, 32'h1234_5678);
    send(1'b1, 5'd31, 32'hFFFF_0000);
    send(1'b0, 5'd31, 32'h0);
    recv("rd31");
    send(1'b0, 5'd0, 32'h0);
    recv("rd0");

    // Backpressure with a second request queued behind the response.
    rsp_ready = 1'b0;
    send(1'b0, 5'd0, 32'h0);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd31;
    @(negedge clk);
    held = rsp_rdata;
    chk("bp_first", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_stable", rsp_rdata, held);
      chk("bp_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    recv("bp_rd0");
    send(1'b0, 5'd31, 32'h0);
    recv("bp_rd31");
`ifdef MEM_REQ_CTRL_STATS_EN
    chk("stat_wr", wr_count, 16'd3);
    chk("stat_rd", rd_count, 16'd5);
`endif

    // Reset while the read is in flight drops it.
    send(1'b0, 5'd7, 32'h0);
    chk("mid_in_read", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_r_w", mem_r_w, 1'b0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_no_rsp", seen, 0);
    send(1'b0, 5'd7, 32'h0);
    recv("post_rd7");
    chk("total_writes", wr_events, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
